// File: rtl/mad_arbiter.sv
// rtl/mad_arbiter.sv - round-robin arbiter sharing one pipelined MAD unit between requesters
module mad_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAD_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_operand_a_i,
  input  logic [NUM_REQ*32-1:0] req_operand_b_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [NUM_REQ*32-1:0] rsp_result_o,
  output logic                  mad_valid_o,
  output logic [31:0]           mad_operand_a_o,
  output logic [31:0]           mad_operand_b_o,
  input  logic [31:0]           mad_result_i,
  output logic                  busy_o
);

  localparam int IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  state_e                          state_q [NUM_REQ];
  state_e                          state_d [NUM_REQ];
  logic [31:0]                     rsp_q   [NUM_REQ];
  logic [31:0]                     rsp_d   [NUM_REQ];
  logic [IdW-1:0]                  ptr_q, ptr_d;
  logic [MAD_LATENCY-1:0]          tag_vld_q, tag_vld_d;
  logic [MAD_LATENCY-1:0][IdW-1:0] tag_id_q, tag_id_d;

  logic [NUM_REQ-1:0] eligible;
  logic               gnt;
  logic [IdW-1:0]     gnt_id;
  logic [IdW-1:0]     scan_idx;
  logic               exit_vld;
  logic [IdW-1:0]     exit_id;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (state_q[i] == ST_IDLE);
    end
  end

  // First eligible index at or after the pointer wins; reset suppresses any grant.
  always_comb begin
    gnt      = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdW'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt && eligible[scan_idx]) begin
        gnt    = 1'b1;
        gnt_id = scan_idx;
      end
    end
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt) begin
      ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + IdW'(1);
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt) begin
      req_ready_o[gnt_id] = 1'b1;
    end
  end

  assign mad_valid_o     = gnt;
  assign mad_operand_a_o = gnt ? req_operand_a_i[32*gnt_id +: 32] : 32'h0;
  assign mad_operand_b_o = gnt ? req_operand_b_i[32*gnt_id +: 32] : 32'h0;

  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = gnt;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s < MAD_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  assign exit_vld = tag_vld_q[MAD_LATENCY-1];
  assign exit_id  = tag_id_q[MAD_LATENCY-1];

  // The result on mad_result_i belongs to whichever id leaves the tag pipeline.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      rsp_d[i]   = rsp_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (req_ready_o[i]) begin
            state_d[i] = ST_INFLIGHT;
          end
        end
        ST_INFLIGHT: begin
          if (exit_vld && (exit_id == IdW'(i))) begin
            state_d[i] = ST_RESP;
            rsp_d[i]   = mad_result_i;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    busy_o      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = (state_q[i] == ST_RESP);
      if (state_q[i] != ST_IDLE) begin
        busy_o = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign rsp_result_o[32*g +: 32] = rsp_q[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= ST_IDLE;
        rsp_q[i]   <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= state_d[i];
        rsp_q[i]   <= rsp_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mad_arbiter.sv
// tb/tb_mad_arbiter.sv - directed self-checking bench for mad_arbiter with a behavioural MAD unit
module tb_mad_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  a_bus;
  logic [127:0]  b_bus;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_ready;
  logic [127:0]  rsp_result;
  logic          mad_valid;
  logic [31:0]   mad_a;
  logic [31:0]   mad_b;
  logic [31:0]   mad_result;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mad_arbiter #(.NUM_REQ(NREQ), .MAD_LATENCY(LAT)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_operand_a_i (a_bus),
    .req_operand_b_i (b_bus),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .mad_valid_o     (mad_valid),
    .mad_operand_a_o (mad_a),
    .mad_operand_b_o (mad_b),
    .mad_result_i    (mad_result),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      s += int'(a[8*k +: 8]) * int'($signed(b[8*k +: 8]));
    end
    return 32'(s);
  endfunction

  // Garbage on idle cycles so unqualified sampling would be visible.
  logic [31:0] mad_pipe [LAT];
  always @(posedge clk) begin
    mad_pipe[0] <= mad_valid ? dot(mad_a, mad_b) : 32'hDEAD_BEEF;
    for (int s = 1; s < LAT; s++) begin
      mad_pipe[s] <= mad_pipe[s-1];
    end
  end
  assign mad_result = mad_pipe[LAT-1];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    a_bus     = '0;
    b_bus     = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (mad_valid !== 1'b0) begin errors++; $display("FAIL reset_mad_valid got %b exp 0", mad_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rsp_result !== 128'h0) begin errors++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result); end
    checks++; if ({mad_a, mad_b} !== 64'h0) begin errors++; $display("FAIL reset_mad_ops got %h exp 0", {mad_a, mad_b}); end
    next_cycle();
  endtask

  task automatic test_single();
    apply_reset();
    rsp_ready      = 4'hF;
    req_valid      = 4'b0001;
    a_bus[31:0]    = 32'h0101_0101;
    b_bus[31:0]    = 32'h0202_0202;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", req_ready); end
    checks++; if (mad_valid !== 1'b1) begin errors++; $display("FAIL single_mad_valid got %b exp 1", mad_valid); end
    checks++; if (mad_a !== 32'h0101_0101 || mad_b !== 32'h0202_0202)
      begin errors++; $display("FAIL single_mad_ops got %h/%h exp 01010101/02020202", mad_a, mad_b); end
    next_cycle();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (busy !== (c <= 3)) begin errors++; $display("FAIL single_busy_c%0d got %b exp %b", c, busy, (c <= 3)); end
      checks++; if (rsp_valid !== ((c == 3) ? 4'b0001 : 4'b0000))
        begin errors++; $display("FAIL single_rsp_valid_c%0d got %b", c, rsp_valid); end
      if (c == 3) begin
        checks++; if (rsp_result[31:0] !== 32'h0000_0008)
          begin errors++; $display("FAIL single_result got %h exp 00000008", rsp_result[31:0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g, exp_r;
    apply_reset();
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_bus[32*i +: 32] = 32'h0101_0101;
      b_bus[32*i +: 32] = {4{8'(i + 1)}};
    end
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      exp_g = (c < 4) ? 4'(1 << c) : 4'b0;
      exp_r = (c >= 3) ? 4'(1 << (c - 3)) : 4'b0;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL cont_grant_c%0d got %b exp %b", c, req_ready, exp_g); end
      checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL cont_rsp_c%0d got %b exp %b", c, rsp_valid, exp_r); end
      if (c >= 3) begin
        checks++; if (rsp_result[32*(c-3) +: 32] !== 32'(4 * (c - 2)))
          begin errors++; $display("FAIL cont_result_r%0d got %h exp %h", c - 3, rsp_result[32*(c-3) +: 32], 32'(4 * (c - 2))); end
      end
      next_cycle();
      if (c < 4) req_valid[c] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    apply_reset();
    rsp_ready = 4'hF;
    req_valid = 4'b0101;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      exp_g = ((c % 4) == 0) ? 4'b0001 : ((c % 4) == 1) ? 4'b0100 : 4'b0000;
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL fair_grant_c%0d got %b exp %b", c, req_ready, exp_g); end
      next_cycle();
    end
    apply_reset();
    rsp_ready = 4'hF;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_r1 got %b exp 0010", req_ready); end
    next_cycle();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_r3 got %b exp 1000", req_ready); end
    next_cycle();
    req_valid = 4'b0101;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_to_r0 got %b exp 0001", req_ready); end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int done;
    done = 0;
    apply_reset();
    rsp_ready = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      a_bus[32*i +: 32] = 32'h0101_0101;
      b_bus[32*i +: 32] = (i == 1) ? 32'h0303_0303 : 32'h0101_0101;
    end
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_grant got %b exp 0010", req_ready); end
    next_cycle();
    req_valid = 4'hF;
    for (int c = 1; c <= 14; c++) begin
      if (c == 13) rsp_ready[1] = 1'b1;
      @(negedge clk);
      if (c >= 3 && c <= 13) begin
        checks++; if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_c%0d got %b exp 1", c, rsp_valid[1]); end
        checks++; if (rsp_result[63:32] !== 32'h0000_000C)
          begin errors++; $display("FAIL bp_hold_result_c%0d got %h exp 0000000c", c, rsp_result[63:32]); end
        checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_no_grant_c%0d got %b exp 0", c, req_ready[1]); end
      end
      if (c >= 3 && c <= 12) begin
        for (int k = 0; k < 4; k++) begin
          if (k != 1 && rsp_valid[k] && rsp_ready[k]) done++;
        end
      end
      if (c == 14) begin
        checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", rsp_valid[1]); end
      end
      next_cycle();
    end
    checks++; if (done !== 7) begin errors++; $display("FAIL bp_others_done got %0d exp 7", done); end
    req_valid = '0;
  endtask

  task automatic test_signed();
    apply_reset();
    rsp_ready       = 4'hF;
    a_bus[31:0]     = 32'h0101_0101;
    b_bus[31:0]     = 32'hFFFF_FFFF;
    a_bus[63:32]    = 32'hFF00_0000;
    b_bus[63:32]    = 32'h8000_0000;
    req_valid       = 4'b0011;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL signed_grant0 got %b exp 0001", req_ready); end
      end
      if (c == 1) begin
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL signed_grant1 got %b exp 0010", req_ready); end
      end
      if (c == 3) begin
        checks++; if (rsp_valid[0] !== 1'b1 || rsp_result[31:0] !== 32'hFFFF_FFFC)
          begin errors++; $display("FAIL signed_r0 got %b/%h exp 1/fffffffc", rsp_valid[0], rsp_result[31:0]); end
      end
      if (c == 4) begin
        checks++; if (rsp_valid[1] !== 1'b1 || rsp_result[63:32] !== 32'hFFFF_8080)
          begin errors++; $display("FAIL signed_r1 got %b/%h exp 1/ffff8080", rsp_valid[1], rsp_result[63:32]); end
      end
      next_cycle();
      if (c < 2) req_valid[c] = 1'b0;
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    rsp_ready   = 4'hF;
    a_bus[31:0] = 32'h0101_0101;
    b_bus[31:0] = 32'h0202_0202;
    req_valid   = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant got %b exp 0001", req_ready); end
    next_cycle();
    rst       = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_priority got %b exp 0000", req_ready); end
    next_cycle();
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL mid_no_rsp_c%0d got %b exp 0000", c, rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_c%0d got %b exp 0", c, busy); end
      next_cycle();
    end
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_restart got %b exp 0001", req_ready); end
    next_cycle();
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    a_bus     = '0;
    b_bus     = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_signed();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
